// File: rtl/fpu_axil_regs.sv
// AXI4-Lite register front end for the FPU core: operand/control registers,
// start pulse generation and result/flag capture for read-back.
module fpu_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [31:0]                     fpu_a,
   output logic [31:0]                     fpu_b,
   output logic [2:0]                      fpu_op,
   output logic                            fpu_start,
   input  logic                            fpu_done,
   input  logic [31:0]                     fpu_result,
   input  logic [4:0]                      fpu_flags
);

   typedef enum logic [1:0] {
      REG_A      = 2'd0,
      REG_B      = 2'd1,
      REG_CTRL   = 2'd2,
      REG_RESULT = 2'd3
   } reg_sel_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic        rdy_en;
   logic        aw_held;
   reg_sel_e    aw_sel_q;
   logic        w_held;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;

   logic [31:0] reg_a;
   logic [31:0] reg_b;
   logic [2:0]  op_q;
   logic        done_q;
   logic        busy_q;
   logic [4:0]  flags_q;
   logic [31:0] result_q;

   logic        aw_hs;
   logic        w_hs;
   logic        ar_hs;
   logic        commit;
   logic        busy_eff;
   logic        done_evt;
   reg_sel_e    wr_sel;
   reg_sel_e    rd_sel;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        start_req;
   logic        start_ok;
   logic [2:0]  new_op;
   logic [1:0]  wr_resp;
   logic [31:0] rd_mux;
   logic [31:0] ctrl_view;

   logic        unused_bits;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign S_AXI_AWREADY = rdy_en && !aw_held && !S_AXI_BVALID;
   assign S_AXI_WREADY  = rdy_en && !w_held && !S_AXI_BVALID;
   assign S_AXI_ARREADY = rdy_en && !S_AXI_RVALID;
   assign S_AXI_RRESP   = RESP_OKAY;

   assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign commit = (aw_hs || aw_held) && (w_hs || w_held);

   // A completion landing on the commit edge frees the core before the start is judged.
   assign done_evt = fpu_done && busy_q;
   assign busy_eff = busy_q && !fpu_done;

   assign ctrl_view = {busy_q, 10'b0, flags_q, 7'b0, done_q, 5'b0, op_q};

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int unsigned i = 0; i < 4; i++)
         if (strb[i])
            res[8*i +: 8] = new_v[8*i +: 8];
      return res;
   endfunction

   always_comb begin
      wr_sel    = aw_hs ? reg_sel_e'(S_AXI_AWADDR[3:2]) : aw_sel_q;
      wr_data   = w_hs ? S_AXI_WDATA : w_data_q;
      wr_strb   = w_hs ? S_AXI_WSTRB : w_strb_q;
      start_req = wr_strb[3] && wr_data[31];
      new_op    = wr_strb[0] ? wr_data[2:0] : op_q;
      start_ok  = commit && (wr_sel == REG_CTRL) && start_req && !busy_eff;
      wr_resp   = RESP_OKAY;
      if (wr_sel == REG_RESULT)
         wr_resp = RESP_SLVERR;
      else if ((wr_sel == REG_CTRL) && start_req && busy_eff)
         wr_resp = RESP_SLVERR;
   end

   always_comb begin
      rd_sel = reg_sel_e'(S_AXI_ARADDR[3:2]);
      rd_mux = '0;
      case (rd_sel)
         REG_A:      rd_mux = reg_a;
         REG_B:      rd_mux = reg_b;
         REG_CTRL:   rd_mux = ctrl_view;
         REG_RESULT: rd_mux = result_q;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         rdy_en       <= 1'b0;
         aw_held      <= 1'b0;
         aw_sel_q     <= REG_A;
         w_held       <= 1'b0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
      end else begin
         rdy_en <= 1'b1;
         if (commit)
            aw_held <= 1'b0;
         else if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_sel_q <= reg_sel_e'(S_AXI_AWADDR[3:2]);
         end
         if (commit)
            w_held <= 1'b0;
         else if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
         end
         if (commit) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_resp;
         end else if (S_AXI_BVALID && S_AXI_BREADY)
            S_AXI_BVALID <= 1'b0;
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         reg_a     <= '0;
         reg_b     <= '0;
         op_q      <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         flags_q   <= '0;
         result_q  <= '0;
         fpu_a     <= '0;
         fpu_b     <= '0;
         fpu_op    <= '0;
         fpu_start <= 1'b0;
      end else begin
         fpu_start <= 1'b0;
         if (done_evt) begin
            result_q <= fpu_result;
            flags_q  <= fpu_flags;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
         end
         if (commit) begin
            case (wr_sel)
               REG_A: reg_a <= merge_bytes(reg_a, wr_data, wr_strb);
               REG_B: reg_b <= merge_bytes(reg_b, wr_data, wr_strb);
               REG_CTRL: begin
                  if (!(start_req && busy_eff))
                     op_q <= new_op;
                  if (start_ok) begin
                     fpu_a     <= reg_a;
                     fpu_b     <= reg_b;
                     fpu_op    <= new_op;
                     fpu_start <= 1'b1;
                     busy_q    <= 1'b1;
                     done_q    <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
      end else begin
         if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_mux;
         end else if (S_AXI_RVALID && S_AXI_RREADY)
            S_AXI_RVALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fpu_axil_regs.sv
// Directed bench for fpu_axil_regs: register access, write ordering, start/done
// handshakes, back-pressure and asynchronous reset.
module tb_fpu_axil_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [3:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic [2:0]  fpu_op;
   logic        fpu_start;
   logic        fpu_done = 1'b0;
   logic [31:0] fpu_result = '0;
   logic [4:0]  fpu_flags = '0;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   logic [1:0]  resp;
   logic        st;
   logic [31:0] rd;

   always #5 clk = ~clk;

   fpu_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_start(fpu_start),
      .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_flags(fpu_flags)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r, output logic start_seen);
      logic aw_acc, w_acc, aw_done, w_done;
      int   n;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; n = 0;
      while (!(aw_done && w_done) && n < 50) begin
         aw_acc = awvalid && awready;
         w_acc  = wvalid && wready;
         step();
         if (aw_acc) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_acc)  begin wvalid = 1'b0; w_done = 1'b1; end
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      while (!bvalid && n < 50) begin step(); n++; end
      check("write_timeout", 32'(n < 50), 32'd1);
      r = bresp;
      start_seen = fpu_start;
      step();
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      logic ar_acc;
      int   n;
      araddr = a; arvalid = 1'b1; n = 0;
      ar_acc = 1'b0;
      while (!ar_acc && n < 50) begin
         ar_acc = arready;
         step();
         n++;
      end
      arvalid = 1'b0;
      check("read_timeout", 32'(rvalid && n < 50), 32'd1);
      check("rresp", 32'(rresp), 32'd0);
      d = rdata;
      step();
   endtask

   task automatic core_done(input logic [31:0] res, input logic [4:0] fl);
      fpu_done = 1'b1; fpu_result = res; fpu_flags = fl;
      step();
      fpu_done = 1'b0;
   endtask

   initial begin
      // reset values
      step(); step();
      check("rst_awready", 32'(awready), 0);
      check("rst_wready", 32'(wready), 0);
      check("rst_arready", 32'(arready), 0);
      check("rst_bvalid", 32'(bvalid), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_rdata", rdata, 0);
      check("rst_fpu_start", 32'(fpu_start), 0);
      rst = 1'b0;
      check("rdy_before_edge", 32'(awready), 0);
      step();
      check("rdy_after_edge", 32'({awready, wready, arready}), 32'h7);

      // basic register access
      axi_write(4'h0, 32'h1, 4'hF, resp, st); check("wr_a_resp", 32'(resp), 0);
      axi_write(4'h4, 32'h2, 4'hF, resp, st); check("wr_b_resp", 32'(resp), 0);
      axi_write(4'h8, 32'h3, 4'hF, resp, st); check("wr_ctrl_resp", 32'(resp), 0);
      axi_read(4'h0, rd); check("rd_a", rd, 32'h1);
      axi_read(4'h4, rd); check("rd_b", rd, 32'h2);
      axi_read(4'h8, rd); check("rd_ctrl", rd, 32'h3);
      axi_read(4'hC, rd); check("rd_result_rst", rd, 32'h0);

      // W three cycles ahead of AW
      wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
      step(); wvalid = 1'b0;
      check("w_held_wready", 32'(wready), 0);
      step(); check("wfirst_no_b1", 32'(bvalid), 0);
      step(); check("wfirst_no_b2", 32'(bvalid), 0);
      awaddr = 4'h0; awvalid = 1'b1;
      step(); awvalid = 1'b0;
      check("wfirst_bvalid", 32'(bvalid), 1);
      check("wfirst_bresp", 32'(bresp), 0);
      step(); check("wfirst_b_done", 32'(bvalid), 0);
      axi_read(4'h0, rd); check("wfirst_a", rd, 32'hDEADBEEF);

      // AW ahead of W
      awaddr = 4'h0; awvalid = 1'b1;
      step(); awvalid = 1'b0;
      check("aw_held_awready", 32'(awready), 0);
      step(); check("awfirst_no_b", 32'(bvalid), 0);
      wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
      step(); wvalid = 1'b0;
      check("awfirst_bvalid", 32'(bvalid), 1);
      step();
      axi_read(4'h0, rd); check("awfirst_a", rd, 32'h12345678);

      // byte strobes
      axi_write(4'h0, 32'h0, 4'hF, resp, st);
      axi_write(4'h0, 32'hDEADBEEF, 4'b0011, resp, st);
      axi_read(4'h0, rd); check("strobe_a", rd, 32'h0000BEEF);

      // start and completion
      axi_write(4'h0, 32'h3F800000, 4'hF, resp, st);
      axi_write(4'h4, 32'h40000000, 4'hF, resp, st);
      axi_write(4'h8, 32'h80000001, 4'hF, resp, st);
      check("start_resp", 32'(resp), 0);
      check("start_pulse", 32'(st), 1);
      check("start_pulse_end", 32'(fpu_start), 0);
      check("snap_a", fpu_a, 32'h3F800000);
      check("snap_b", fpu_b, 32'h40000000);
      check("snap_op", 32'(fpu_op), 32'd1);
      axi_read(4'h8, rd); check("ctrl_busy", rd, 32'h80000001);
      core_done(32'h40400000, 5'h01);
      axi_read(4'hC, rd); check("result1", rd, 32'h40400000);
      axi_read(4'h8, rd); check("ctrl_done", rd, 32'h00010101);

      // start while busy, writes while busy, RESULT write
      axi_write(4'h8, 32'h80000001, 4'hF, resp, st);
      check("start2_pulse", 32'(st), 1);
      axi_write(4'h0, 32'h11111111, 4'hF, resp, st);
      check("busy_a_resp", 32'(resp), 0);
      axi_write(4'h8, 32'h80000005, 4'hF, resp, st);
      check("busy_start_resp", 32'(resp), 32'd2);
      check("busy_start_pulse", 32'(st), 0);
      check("busy_snap_a", fpu_a, 32'h3F800000);
      check("busy_snap_op", 32'(fpu_op), 32'd1);
      axi_write(4'h8, 32'h00000004, 4'hF, resp, st);
      check("busy_op_resp", 32'(resp), 0);
      check("busy_op_snap", 32'(fpu_op), 32'd1);
      axi_read(4'h8, rd); check("busy_ctrl", rd, 32'h80010004);
      axi_write(4'hC, 32'h55, 4'hF, resp, st);
      check("result_wr_resp", 32'(resp), 32'd2);
      axi_read(4'hC, rd); check("result_unchanged", rd, 32'h40400000);

      // completion coincident with a start commit
      awaddr = 4'h8; awvalid = 1'b1;
      wdata = 32'h80000006; wstrb = 4'hF; wvalid = 1'b1;
      fpu_done = 1'b1; fpu_result = 32'h3F000000; fpu_flags = 5'h02;
      step();
      awvalid = 1'b0; wvalid = 1'b0; fpu_done = 1'b0;
      check("coin_bvalid", 32'(bvalid), 1);
      check("coin_bresp", 32'(bresp), 0);
      check("coin_start", 32'(fpu_start), 1);
      check("coin_snap_a", fpu_a, 32'h11111111);
      check("coin_snap_op", 32'(fpu_op), 32'd6);
      step();
      axi_read(4'hC, rd); check("coin_result", rd, 32'h3F000000);
      axi_read(4'h8, rd); check("coin_ctrl", rd, 32'h80020006);
      core_done(32'h40800000, 5'h00);
      axi_read(4'h8, rd); check("done2_ctrl", rd, 32'h00000106);
      core_done(32'hFFFFFFFF, 5'h1F);
      axi_read(4'hC, rd); check("idle_done_result", rd, 32'h40800000);
      axi_read(4'h8, rd); check("idle_done_ctrl", rd, 32'h00000106);

      // read back-pressure
      rready = 1'b0; araddr = 4'h0; arvalid = 1'b1;
      step(); arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_rvalid", 32'(rvalid), 1);
         check("bp_rdata", rdata, 32'h11111111);
         check("bp_arready", 32'(arready), 0);
         step();
      end
      rready = 1'b1;
      step(); check("bp_r_done", 32'(rvalid), 0);

      // write back-pressure
      bready = 1'b0; awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1;
      step(); awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_bvalid", 32'(bvalid), 1);
         check("bp_bresp", 32'(bresp), 32'd2);
         check("bp_awready", 32'(awready), 0);
         step();
      end
      bready = 1'b1;
      step(); check("bp_b_done", 32'(bvalid), 0);

      // asynchronous reset in the middle of a write
      rst = 1'b1; step(); rst = 1'b0; step();
      axi_write(4'h8, 32'h80000001, 4'hF, resp, st);
      check("pre_rst_start", 32'(st), 1);
      axi_read(4'h0, rd); check("pre_rst_a", rd, 32'h0);
      wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
      step(); wvalid = 1'b0;
      awaddr = 4'h0; awvalid = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'({awready, wready, arready}), 0);
      check("mid_rst_valid", 32'({bvalid, rvalid, fpu_start}), 0);
      check("mid_rst_resp", 32'({bresp, rresp}), 0);
      check("mid_rst_rdata", rdata, 0);
      check("mid_rst_op", 32'(fpu_op), 0);
      awvalid = 1'b0;
      step(); rst = 1'b0; step();
      check("post_rst_no_b", 32'(bvalid), 0);
      axi_read(4'h0, rd); check("post_rst_a", rd, 32'h0);
      axi_read(4'h8, rd); check("post_rst_ctrl", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_axil_regs.md
# fpu_axil_regs

AXI4-Lite slave (responder) fronting the FPU core: it answers the same single-beat write/read sequences the master VIP issues at offsets 0x0–0xC. It holds operand registers, issues a start pulse to the FPU datapath, and captures the result and flags for read-back. It sits between the AXI interconnect and the FPU core inside the FPU IP.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; 4 word registers.
- S_AXI_ACLK  in  1  single clock; all logic on the rising edge.
- S_AXI_ARESET  in  1  reset, asynchronous, active-high.
- S_AXI_AWADDR / S_AXI_AWPROT / S_AXI_AWVALID / S_AXI_AWREADY  in/in/in/out  4/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WVALID / S_AXI_WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP / S_AXI_BVALID / S_AXI_BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / S_AXI_ARPROT / S_AXI_ARVALID / S_AXI_ARREADY  in/in/in/out  4/3/1/1  read address channel.
- S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID / S_AXI_RREADY  out/out/out/in  32/2/1/1  read data channel.
- fpu_a, fpu_b  out  32  operand snapshot, latched at start.
- fpu_op  out  3  opcode snapshot, latched at start.
- fpu_start  out  1  one-cycle start pulse.
- fpu_done  in  1  one-cycle completion pulse from the core.
- fpu_result  in  32  result, valid with fpu_done.
- fpu_flags  in  5  exception flags, valid with fpu_done.

## Operation
- Register map, decoded on addr[3:2]:
  - 0x0 A: read/write.
  - 0x4 B: read/write.
  - 0x8 CTRL: [2:0] op (read/write); [8] done (sticky, read-only); [20:16] flags (read-only); [31] busy on read, start on write.
  - 0xC RESULT: read-only.
- WSTRB applies per byte to A, B and CTRL[2:0]. Strobe byte 3 gates the start bit.
- Write channel:
  - AW and W are accepted independently and in either order; each is held in a one-entry holding register.
  - The write commits once both are present. That is the edge where each of AW and W was either handshaken this cycle or already held.
  - BVALID is set at that same edge and the holding flags clear.
- Start:
  - A CTRL write with WDATA[31]=1 (strobe 3 set) while not busy: fpu_a/fpu_b/fpu_op ← A/B/op (after this write's op update); fpu_start=1 for one cycle; busy←1; done←0; flags unchanged; BRESP=OKAY.
  - A start while busy is ignored, including the op field; BRESP=SLVERR.
  - A write to RESULT has no effect; BRESP=SLVERR.
  - A, B and op writes while busy are allowed and do not disturb the snapshot.
- Completion:
  - fpu_done while busy: RESULT←fpu_result, flags←fpu_flags, done←1, busy←0.
  - fpu_done while not busy is ignored.
  - fpu_done and a start commit at the same edge: the completion is applied first, then the start is accepted (busy stays 1, done 0, RESULT updated, OKAY).
- Read channel:
  - On AR handshake, RDATA is latched from the addressed register and RVALID←1; RRESP is always OKAY.
  - RDATA/RRESP are held stable until RREADY.
  - A read and a write in the same cycle are independent. A read of a register committed at the same edge returns the old value.

## Timing
- Reset values (during reset): all READY, BVALID, RVALID and fpu_start = 0; RDATA, BRESP, RRESP = 0; A, B, CTRL, RESULT, fpu_a, fpu_b, fpu_op = 0.
- READY outputs go high on the first edge after reset release.
- Ready rules:
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - ARREADY = !RVALID.
- Write latency: BVALID is high the cycle after the later of the two handshakes. The register value is visible in that same cycle. Back-to-back writes accept the next AW/W the cycle after B completes.
- Read latency: RVALID is high the cycle after the AR handshake; one read is outstanding at a time.
- fpu_start is high the cycle after the commit edge, i.e. together with BVALID.
- Asynchronous reset mid-transaction drops all held AW/W, pending B/R and busy immediately; no response is issued afterwards.

## Test plan
- Write 0x1, 0x2, 0x3 to 0x0, 0x4, 0x8, then read back -> 0x1, 0x2, 0x3 (CTRL: op=3, busy=0, done=0), all OKAY. Read 0xC -> 0x0.
- W with 0xDEADBEEF issued 3 cycles before AW 0x0 -> one BVALID, 1 cycle after AW; A=0xDEADBEEF. Repeat with AW first, and with WSTRB=0b0011 over A=0 -> A=0x0000BEEF.
- A=0x3F800000, B=0x40000000, write CTRL=0x80000001 -> fpu_start pulse, fpu_a/b/op match, CTRL read → 0x80000001. Core returns done, result 0x40400000, flags 0x01 -> RESULT=0x40400000, CTRL=0x00010101.
- Start while busy -> BRESP=SLVERR, no fpu_start, snapshot unchanged. Write 0xC -> SLVERR, RESULT unchanged.
- fpu_done coincident with a start commit -> RESULT updated, busy stays 1, done=0, new fpu_start pulse, OKAY.
- Hold RREADY/BREADY low for 5 cycles -> RDATA/BRESP stable, ARREADY/AWREADY low. Assert reset mid-write -> all outputs 0, A unchanged from its pre-write value.
